// File: rtl/reg_dep_scoreboard_pkg.sv
// rtl/reg_dep_scoreboard_pkg.sv - shared constants and types for the register dependency scoreboard
package reg_dep_scoreboard_pkg;
    localparam int ROB_WIDTH_BIT = 3;
    localparam int REG_ID_WIDTH  = 5;
    localparam int NUM_REGS      = 32;

    typedef logic [ROB_WIDTH_BIT-1:0] rob_tag_t;
    typedef logic [REG_ID_WIDTH-1:0]  reg_id_t;
endpackage

// File: rtl/reg_dep_scoreboard_if.sv
// rtl/reg_dep_scoreboard_if.sv - issue/commit/flush, operand lookup and regfile write-port bundle
interface reg_dep_scoreboard_if;
    import reg_dep_scoreboard_pkg::*;

    logic        iss_valid;
    reg_id_t     iss_rd;
    rob_tag_t    iss_tag;
    logic        cmt_valid;
    reg_id_t     cmt_rd;
    rob_tag_t    cmt_tag;
    logic [31:0] cmt_val;
    logic        flush_in;
    reg_id_t     q_id1;
    reg_id_t     q_id2;
    logic        q_has_dep1;
    logic        q_has_dep2;
    rob_tag_t    q_dep1;
    rob_tag_t    q_dep2;
    logic        q_fwd1;
    logic        q_fwd2;
    logic [31:0] q_fwdval1;
    logic [31:0] q_fwdval2;
    reg_id_t     set_reg_id;
    logic [31:0] set_val;

    modport master (
        output iss_valid, iss_rd, iss_tag, cmt_valid, cmt_rd, cmt_tag, cmt_val,
               flush_in, q_id1, q_id2,
        input  q_has_dep1, q_has_dep2, q_dep1, q_dep2, q_fwd1, q_fwd2,
               q_fwdval1, q_fwdval2, set_reg_id, set_val
    );

    modport slave (
        input  iss_valid, iss_rd, iss_tag, cmt_valid, cmt_rd, cmt_tag, cmt_val,
               flush_in, q_id1, q_id2,
        output q_has_dep1, q_has_dep2, q_dep1, q_dep2, q_fwd1, q_fwd2,
               q_fwdval1, q_fwdval2, set_reg_id, set_val
    );
endinterface

// File: rtl/reg_dep_lookup.sv
// rtl/reg_dep_lookup.sv - one operand lookup port with commit and pending-write forwarding
module reg_dep_lookup
    import reg_dep_scoreboard_pkg::*;
(
    input  reg_id_t     q_id,
    input  logic        entry_busy,
    input  rob_tag_t    entry_dep,
    input  logic        cmt_valid,
    input  reg_id_t     cmt_rd,
    input  rob_tag_t    cmt_tag,
    input  logic [31:0] cmt_val,
    input  reg_id_t     set_reg_id,
    input  logic [31:0] set_val,
    output logic        has_dep,
    output rob_tag_t    dep,
    output logic        fwd,
    output logic [31:0] fwdval
);
    always_comb begin
        has_dep = entry_busy;
        dep     = entry_dep;
        fwd     = 1'b0;
        fwdval  = 32'd0;
        if (q_id == '0) begin
            has_dep = 1'b0;
            dep     = '0;
        end else if (cmt_valid && cmt_rd == q_id && entry_busy && entry_dep == cmt_tag) begin
            has_dep = 1'b0;
            fwd     = 1'b1;
            fwdval  = cmt_val;
        end else if (set_reg_id == q_id && !entry_busy) begin
            // last cycle's commit has not reached the register file yet
            fwd    = 1'b1;
            fwdval = set_val;
        end
    end
endmodule

// File: rtl/reg_dep_scoreboard.sv
// rtl/reg_dep_scoreboard.sv - register busy/tag table and regfile write port; SCOREBOARD_STATS_EN adds event counters
module reg_dep_scoreboard
    import reg_dep_scoreboard_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    reg_dep_scoreboard_if.slave sb
`ifdef SCOREBOARD_STATS_EN
    ,
    output logic [31:0]        stat_issue,
    output logic [31:0]        stat_commit,
    output logic [31:0]        stat_stale,
    output logic [31:0]        stat_flush
`endif
);
    logic [NUM_REGS-1:0] busy;
    rob_tag_t            dep [NUM_REGS];
    logic                cmt_live;
    logic                cmt_match;
    logic                iss_accept;

    // a paused commit is not applied, so it must not be forwarded either
    assign cmt_live   = sb.cmt_valid && rdy_in;
    assign cmt_match  = sb.cmt_valid && busy[sb.cmt_rd] && dep[sb.cmt_rd] == sb.cmt_tag;
    assign iss_accept = sb.iss_valid && sb.iss_rd != '0 && !sb.flush_in;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy          <= '0;
            for (int i = 0; i < NUM_REGS; i++) dep[i] <= '0;
            sb.set_reg_id <= '0;
            sb.set_val    <= 32'd0;
        end else if (rdy_in) begin
            if (sb.cmt_valid && sb.cmt_rd != '0) begin
                sb.set_reg_id <= sb.cmt_rd;
                sb.set_val    <= sb.cmt_val;
            end else begin
                sb.set_reg_id <= '0;
            end
            for (int i = 1; i < NUM_REGS; i++) begin
                if (sb.flush_in) begin
                    busy[i] <= 1'b0;
                end else if (iss_accept && sb.iss_rd == reg_id_t'(i)) begin
                    busy[i] <= 1'b1;
                    dep[i]  <= sb.iss_tag;
                end else if (cmt_match && sb.cmt_rd == reg_id_t'(i)) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    reg_dep_lookup u_lookup1 (
        .q_id       (sb.q_id1),
        .entry_busy (busy[sb.q_id1]),
        .entry_dep  (dep[sb.q_id1]),
        .cmt_valid  (cmt_live),
        .cmt_rd     (sb.cmt_rd),
        .cmt_tag    (sb.cmt_tag),
        .cmt_val    (sb.cmt_val),
        .set_reg_id (sb.set_reg_id),
        .set_val    (sb.set_val),
        .has_dep    (sb.q_has_dep1),
        .dep        (sb.q_dep1),
        .fwd        (sb.q_fwd1),
        .fwdval     (sb.q_fwdval1)
    );

    reg_dep_lookup u_lookup2 (
        .q_id       (sb.q_id2),
        .entry_busy (busy[sb.q_id2]),
        .entry_dep  (dep[sb.q_id2]),
        .cmt_valid  (cmt_live),
        .cmt_rd     (sb.cmt_rd),
        .cmt_tag    (sb.cmt_tag),
        .cmt_val    (sb.cmt_val),
        .set_reg_id (sb.set_reg_id),
        .set_val    (sb.set_val),
        .has_dep    (sb.q_has_dep2),
        .dep        (sb.q_dep2),
        .fwd        (sb.q_fwd2),
        .fwdval     (sb.q_fwdval2)
    );

`ifdef SCOREBOARD_STATS_EN
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            stat_issue  <= 32'd0;
            stat_commit <= 32'd0;
            stat_stale  <= 32'd0;
            stat_flush  <= 32'd0;
        end else if (rdy_in) begin
            if (iss_accept && stat_issue != '1) stat_issue <= stat_issue + 32'd1;
            if (sb.cmt_valid && stat_commit != '1) stat_commit <= stat_commit + 32'd1;
            if (sb.cmt_valid && sb.cmt_rd != '0 && !cmt_match && stat_stale != '1)
                stat_stale <= stat_stale + 32'd1;
            if (sb.flush_in && stat_flush != '1) stat_flush <= stat_flush + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_reg_dep_scoreboard.sv
// tb/tb_reg_dep_scoreboard.sv - directed-vector bench for reg_dep_scoreboard
module tb_reg_dep_scoreboard;
    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    int   vectors = 0;
    int   miscompares = 0;

`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stat_issue, stat_commit, stat_stale, stat_flush;
`endif

    reg_dep_scoreboard_if bif ();

    reg_dep_scoreboard dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .sb     (bif.slave)
`ifdef SCOREBOARD_STATS_EN
        ,
        .stat_issue  (stat_issue),
        .stat_commit (stat_commit),
        .stat_stale  (stat_stale),
        .stat_flush  (stat_flush)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        bif.iss_valid = 1'b0;
        bif.cmt_valid = 1'b0;
        bif.flush_in  = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [2:0] tag);
        bif.iss_valid = 1'b1;
        bif.iss_rd    = rd;
        bif.iss_tag   = tag;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [2:0] tag, input logic [31:0] val);
        bif.cmt_valid = 1'b1;
        bif.cmt_rd    = rd;
        bif.cmt_tag   = tag;
        bif.cmt_val   = val;
    endtask

    initial begin
        rst_in = 1'b0;
        rdy_in = 1'b1;
        idle();
        bif.iss_rd = '0; bif.iss_tag = '0;
        bif.cmt_rd = '0; bif.cmt_tag = '0; bif.cmt_val = '0;
        bif.q_id1 = 5'd5; bif.q_id2 = 5'd0;
        #12;
        chk("rst_has_dep", bif.q_has_dep1, 0);
        chk("rst_fwd", bif.q_fwd1, 0);
        chk("rst_set_reg_id", bif.set_reg_id, 0);
        chk("rst_set_val", bif.set_val, 0);
        rst_in = 1'b1;
        step();

        // issue x5 tag 2
        issue(5, 2);
        step(); idle();
        chk("x5_busy", bif.q_has_dep1, 1);
        chk("x5_dep", bif.q_dep1, 2);
        chk("x5_nofwd", bif.q_fwd1, 0);

        // commit x5 with same-cycle lookup
        commit(5, 2, 32'hDEADBEEF);
        #1;
        chk("cmt_fwd_has_dep", bif.q_has_dep1, 0);
        chk("cmt_fwd", bif.q_fwd1, 1);
        chk("cmt_fwdval", bif.q_fwdval1, 32'hDEADBEEF);
        step(); idle();
        chk("wr5_id", bif.set_reg_id, 5);
        chk("wr5_val", bif.set_val, 32'hDEADBEEF);
        chk("pend_fwd", bif.q_fwd1, 1);
        chk("pend_fwdval", bif.q_fwdval1, 32'hDEADBEEF);
        step();
        chk("wr_idle_id", bif.set_reg_id, 0);
        chk("x5_idle_fwd", bif.q_fwd1, 0);

        // stale commit on x7
        issue(7, 1); step();
        issue(7, 4); step(); idle();
        bif.q_id2 = 5'd7;
        commit(7, 1, 32'h77);
        #1;
        chk("stale_same_has_dep", bif.q_has_dep2, 1);
        chk("stale_same_fwd", bif.q_fwd2, 0);
        step(); idle();
        chk("stale_has_dep", bif.q_has_dep2, 1);
        chk("stale_dep", bif.q_dep2, 4);
        chk("stale_wr_id", bif.set_reg_id, 7);
        chk("stale_wr_val", bif.set_val, 32'h77);
        chk("stale_busy_nofwd", bif.q_fwd2, 0);

        // issue and commit to x3 in the same cycle
        issue(3, 6); commit(3, 5, 32'h33);
        step(); idle();
        bif.q_id1 = 5'd3;
        #1;
        chk("x3_issue_wins", bif.q_has_dep1, 1);
        chk("x3_dep", bif.q_dep1, 6);

        // busy x1 and x2, then flush with commit and issue
        issue(1, 0); step();
        issue(2, 1); step(); idle();
        bif.q_id1 = 5'd1; bif.q_id2 = 5'd2;
        #1;
        chk("x1_busy", bif.q_has_dep1, 1);
        chk("x2_busy", bif.q_has_dep2, 1);
        bif.flush_in = 1'b1; commit(1, 0, 32'd9); issue(4, 3);
        step(); idle();
        bif.q_id2 = 5'd4;
        #1;
        chk("flush_x1", bif.q_has_dep1, 0);
        chk("flush_x1_fwd", bif.q_fwd1, 1);
        chk("flush_x1_fwdval", bif.q_fwdval1, 9);
        chk("flush_x4_dropped", bif.q_has_dep2, 0);
        chk("flush_wr_id", bif.set_reg_id, 1);
        chk("flush_wr_val", bif.set_val, 9);
        bif.q_id1 = 5'd2; bif.q_id2 = 5'd3;
        #1;
        chk("flush_x2", bif.q_has_dep1, 0);
        chk("flush_x3", bif.q_has_dep2, 0);
        bif.q_id1 = 5'd7;
        #1;
        chk("flush_x7", bif.q_has_dep1, 0);

        // x0 is never busy
        issue(0, 5); step(); idle();
        bif.q_id1 = 5'd0;
        #1;
        chk("x0_has_dep", bif.q_has_dep1, 0);
        chk("x0_fwd", bif.q_fwd1, 0);
        chk("x0_no_write", bif.set_reg_id, 0);

        // rdy_in low freezes table and write port
        issue(9, 3); commit(7, 4, 32'h1234);
        step(); idle();
        chk("pre_pause_wr_id", bif.set_reg_id, 7);
        rdy_in = 1'b0;
        issue(6, 2); commit(9, 3, 32'h55);
        step(); idle();
        bif.q_id1 = 5'd6; bif.q_id2 = 5'd9;
        #1;
        chk("pause_wr_id_hold", bif.set_reg_id, 7);
        chk("pause_wr_val_hold", bif.set_val, 32'h1234);
        chk("pause_x6_not_busy", bif.q_has_dep1, 0);
        chk("pause_x9_busy", bif.q_has_dep2, 1);
        chk("pause_x9_dep", bif.q_dep2, 3);
        rdy_in = 1'b1;
        step();
        chk("resume_wr_id", bif.set_reg_id, 0);
        chk("resume_x9_busy", bif.q_has_dep2, 1);

`ifdef SCOREBOARD_STATS_EN
        chk("stat_flush", stat_flush, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/reg_dep_scoreboard.md
Name: reg_dep_scoreboard

Overview:
- Controls the architectural register file: owns the per-register dependency table (busy bit plus ROB tag) and drives the register file's single write port from ROB commits.
- Sits between decode/issue (allocates rd tags), the ROB (commits and flushes) and the register file (write port).
- Serves two operand lookups with commit/write forwarding, so a dispatching instruction sees a consistent value or tag in the same cycle.

Parameters:
- ROB_WIDTH_BIT, 3, ROB tag width; the value is taken from the shared constants.
- NUM_REGS, 32, number of architectural registers; the register index is 5 bits.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset, asynchronous, active-low
- rdy_in  in  1  pause when low
- iss_valid  in  1  issue allocates rd
- iss_rd  in  5  destination register
- iss_tag  in  ROB_WIDTH_BIT  ROB tag of the issuing instruction
- cmt_valid  in  1  ROB commit
- cmt_rd  in  5  committed destination
- cmt_tag  in  ROB_WIDTH_BIT  committed ROB tag
- cmt_val  in  32  committed value
- flush_in  in  1  mispredict flush
- q_id1/q_id2  in  5  lookup register indices
- q_has_dep1/q_has_dep2  out  1  operand still pending
- q_dep1/q_dep2  out  ROB_WIDTH_BIT  producing ROB tag
- q_fwd1/q_fwd2  out  1  use q_fwdval instead of the register file value
- q_fwdval1/q_fwdval2  out  32  forwarded value
- set_reg_id  out  5  register file write index; 0 means no write
- set_val  out  32  register file write data

Behaviour:
- Reset (rst_in low, asynchronous):
  - all has_dep cleared, all dep = 0
  - set_reg_id = 0, set_val = 0, pending-write register cleared
  - lookup outputs reflect the cleared tables (all 0)
- rdy_in low:
  - no table or write-port update
  - set_reg_id/set_val hold their values, but the register file also ignores them while rdy_in is low
  - lookups stay combinational
- Commit write path:
  - one-cycle latency
  - a commit in cycle N with cmt_rd != 0 gives set_reg_id = cmt_rd and set_val = cmt_val in cycle N+1
  - otherwise set_reg_id = 0
  - the write is never suppressed by flush, because committed state is architectural
- Dependency clear:
  - on commit, has_dep[cmt_rd] is cleared only if has_dep is set and dep[cmt_rd] == cmt_tag
  - a stale commit (tag mismatch) leaves the entry untouched
- Issue:
  - iss_valid with iss_rd != 0 sets has_dep[iss_rd] = 1 and dep[iss_rd] = iss_tag
  - iss_rd == 0 is ignored; x0 is never busy
- Issue and commit to the same rd in the same cycle: issue wins; the entry holds the new tag and busy = 1.
- Flush:
  - clears every has_dep in that cycle
  - a same-cycle issue is dropped
  - a same-cycle commit still produces its write
- Lookup (combinational), priority highest first:
  1. q_id == 0: has_dep = 0, fwd = 0.
  2. Current commit to q_id whose tag matches dep[q_id] while busy: has_dep = 0, fwd = 1, fwdval = cmt_val.
  3. Pending registered write with set_reg_id == q_id, and the entry is not busy: fwd = 1, fwdval = set_val.
  4. Otherwise has_dep/dep come from the table and fwd = 0.
  - A same-cycle issue is not visible to lookups; decode handles intra-bundle hazards.
- ROB tags wrap modulo 2^ROB_WIDTH_BIT. Only equality is compared, no ordering.

Optional Feature:
- Macro: SCOREBOARD_STATS_EN.
- When defined, adds four 32-bit saturating counters, exported as outputs stat_issue, stat_commit, stat_stale, stat_flush:
  - stat_issue counts accepted issues (rd != 0, no flush)
  - stat_commit counts commits
  - stat_stale counts tag-mismatch commits
  - stat_flush counts flushes
- Counters reset to 0 and do not advance while rdy_in is low.
- When not defined, the ports and logic are absent.

Decomposition:
- Shared constants: ROB_WIDTH_BIT and the register index width (5).
- Natural sub-module: reg_dep_lookup, the combinational per-port lookup and forward priority logic, instantiated twice.

Test Plan:
- Reset, then lookup x5 -> has_dep = 0, fwd = 0; set_reg_id = 0.
- Issue rd = 5, tag 2; next cycle lookup x5 -> has_dep = 1, dep = 2.
- Commit rd = 5, tag 2, val 0xDEADBEEF with a same-cycle lookup x5:
  - same cycle: has_dep = 0, fwd = 1, fwdval = 0xDEADBEEF
  - next cycle: set_reg_id = 5, set_val = 0xDEADBEEF
- Issue rd = 7 tag 1, then issue rd = 7 tag 4, then commit rd = 7 tag 1 -> entry still busy with dep = 4 (stale commit); set_reg_id = 7 the next cycle.
- Same cycle: issue rd = 3 tag 6, commit rd = 3 tag 5 -> has_dep[3] = 1, dep = 6.
- Busy x1, x2; same cycle: flush, commit rd = 1 val 9, issue rd = 4 -> all clear, x4 not busy, set_reg_id = 1 / set_val = 9 the next cycle.
- Issue rd = 0 -> x0 is never busy.
- Hold rdy_in low while issue and commit are presented -> no table change.
